// File: rtl/hex_display_pkg.sv
// Shared types and active-high seven-segment glyphs for the hex display scanner.
package hex_display_pkg;

  localparam int DIGITS_C = 8;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  // Segment order is {g,f,e,d,c,b,a}; a 1 means the segment is lit.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/hex_display_driver_hex_to_seg7.sv
// Combinational nibble-to-glyph lookup; output is active-high, the parent applies pin polarity.
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_driver.sv
// 8-digit multiplexed seven-segment scanner with frame-boundary double buffering.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int DIGITS         = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int                CNT_W       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_MAX     = CNT_W'(REFRESH_DIV - 1);
  localparam digit_idx_t        LAST_DIGIT  = digit_idx_t'(DIGITS - 1);
  localparam logic              POL_INV     = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0] div_cnt;
  digit_idx_t       digit_idx;
  digit_idx_t       idx_next;
  logic [31:0]      shown;
  logic [31:0]      shown_next;
  logic [31:0]      pending;
  logic             pending_flag;
  logic             tick;
  logic             boundary;
  nibble_t          nibble_next;
  logic [6:0]       glyph_next;
  logic             blank_next;
  logic [6:0]       seg_on;
  logic [7:0]       an_on;

  assign tick     = (div_cnt == DIV_MAX);
  assign boundary = tick && (digit_idx == LAST_DIGIT);
  assign dp       = POL_INV;

  // A strobe landing on the boundary edge bypasses the pending buffer.
  always_comb begin
    idx_next   = (digit_idx == LAST_DIGIT) ? digit_idx_t'(0) : digit_idx + 3'd1;
    shown_next = shown;
    if (boundary) begin
      if (value_valid) begin
        shown_next = value_in;
      end else if (pending_flag) begin
        shown_next = pending;
      end
    end
  end

  assign nibble_next = shown_next[{idx_next, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_next),
    .glyph  (glyph_next)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // nz_above[k] is set when digit k or any higher digit is non-zero.
  logic [7:0] nz_above;
  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz_above[gi] = |shown_next[31:4*gi];
  end
  assign blank_next = (idx_next != digit_idx_t'(0)) && !nz_above[idx_next];
`else
  assign blank_next = 1'b0;
`endif

  assign seg_on = blank_next ? 7'h00 : glyph_next;
  assign an_on  = 8'h01 << idx_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt      <= '0;
      digit_idx    <= LAST_DIGIT;
      shown        <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
      an           <= {8{POL_INV}};
      seg          <= {7{POL_INV}};
      frame_start  <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      frame_start <= boundary;
      shown       <= shown_next;
      if (tick) begin
        digit_idx <= idx_next;
        an        <= an_on ^ {8{POL_INV}};
        seg       <= seg_on ^ {7{POL_INV}};
      end
      if (boundary) begin
        pending_flag <= 1'b0;
      end else if (value_valid) begin
        pending      <= value_in;
        pending_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
Time-multiplexed 8-digit seven-segment scanner that consumes the CPU's 32-bit debug_hex_display word and drives the board's common-anode display. Sits directly downstream of the master core. Words are double-buffered and committed only at frame boundaries, so a mid-scan update never produces a torn frame.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; must be >= 2
DIGITS, 8, number of hex digits scanned; fixed at 8 for a 32-bit word
SEG_ACTIVE_LOW, 1, 1 = a lit segment or anode drives 0; 0 = a lit segment or anode drives 1

Ports:
clk  input  1  single system clock
rst  input  1  asynchronous, active-low reset
value_in  input  32  word to display; digit k = value_in[4k+3:4k]
value_valid  input  1  1-cycle load strobe; captures value_in into the pending buffer
an  output  8  digit enables; one-hot when active, SEG_ACTIVE_LOW polarity
seg  output  7  segments {g,f,e,d,c,b,a}, SEG_ACTIVE_LOW polarity
dp  output  1  decimal point; always off
frame_start  output  1  1-cycle pulse when digit 0 becomes active (frame commit)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst.
- Reset values:
  - div_cnt = 0, digit_idx = 7, shown = 0, pending = 0, pending_flag = 0.
  - an, seg and dp all inactive (8'hFF / 7'h7F / 1 when SEG_ACTIVE_LOW = 1); frame_start = 0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted for the one cycle in which div_cnt == REFRESH_DIV-1.
- Scan:
  - On tick, digit_idx advances: 7 -> 0, otherwise +1.
  - an and seg are registered on the same edge to reflect the new digit_idx.
  - Latency from tick to the new digit on the pins is exactly 1 clock edge.
  - Only one anode is ever active after the first tick.
- Frame boundary = a tick while digit_idx == 7. On that edge:
  - frame_start = 1 for one cycle.
  - shown <= pending if pending_flag is set, and pending_flag is cleared.
  - The first boundary occurs REFRESH_DIV cycles after reset release.
- Load:
  - value_valid captures value_in into pending and sets pending_flag; back-to-back strobes keep the last word.
  - value_valid coinciding with a frame boundary: value_in goes directly into shown and pending_flag stays clear (bypass).
- Decode:
  - seg is the hex glyph of shown[4*digit_idx +: 4]; 0-9 and A-F use the standard glyphs, with lowercase b and d.
  - Example: 4'h0 -> 7'b1000000 active-low.
- Reset mid-frame: all outputs go inactive immediately (asynchronous); the pending word is discarded.
- value_in is sampled only when value_valid = 1; it is ignored otherwise.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is blanked (segments off, anode still scanned) when it and every higher digit are zero.
  - Digit 0 is never blanked, so 32'h0 shows "0" and 32'h00000A30 shows "A30".
- Undefined: all 8 digits are always shown, including zeros.

Decomposition:
- Package hex_display_pkg holds:
  - DIGITS_C = 8.
  - The SEG_* glyph constant table (16 x 7-bit, active-high form).
  - typedef digit_idx_t (logic [2:0]) and nibble_t (logic [3:0]).
- Sub-module hex_to_seg7:
  - Purely combinational: nibble_t in, 7-bit active-high glyph out.
  - Polarity inversion is applied in the parent.

Test Plan:
- Reset, REFRESH_DIV = 4: hold rst low 3 cycles, then release.
  - an = 8'hFF until the first tick.
  - At cycle 4: an = 8'hFE, frame_start pulses, seg = glyph(0) = 7'h40.
- value_in = 32'h12345678 with value_valid at cycle 10:
  - The digits are unchanged until the next frame boundary.
  - Then the scan shows 8,7,6,5,4,3,2,1 on an[0..7], one per 4 cycles.
- Strobe exactly on the boundary cycle with 32'hDEADBEEF:
  - The same frame shows F on digit 0.
  - pending_flag reads 0 afterwards.
- Two strobes in one frame (32'h1111_1111 then 32'h2222_2222): the next frame shows all 2s.
- Assert rst mid-frame at digit 4: an and seg go inactive asynchronously; after release the display restarts with 32'h0.
- LEADING_ZERO_BLANK_EN defined, value 32'h00000A30:
  - Digits 3-7 are blanked (seg = 7'h7F).
  - Digits 0-2 show 0, 3, A.
